// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - arbitrates fetch and load/store ports onto one shared memory bus
module bus_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int WAIT_CYCLES  = 1,
    parameter int MEM_PRIORITY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_ready_o,
    output logic              bus_ce_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_data_o,
    input  logic [DATA_W-1:0] bus_data_i,
    output logic              stallreq_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic GNT_IF  = 1'b0;
    localparam logic GNT_MEM = 1'b1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic       grant;
    logic       rr_last;
    logic       start;
    logic       start_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // start marks an edge that launches a new access, from IDLE or back-to-back from RESP
    always_comb begin
        state_next = state;
        start      = 1'b0;
        start_gnt  = GNT_IF;
        case (state)
            IDLE: begin
                if (if_ce_i && mem_ce_i) begin
                    start     = 1'b1;
                    start_gnt = (MEM_PRIORITY != 0) ? GNT_MEM : ~rr_last;
                end else if (if_ce_i || mem_ce_i) begin
                    start     = 1'b1;
                    start_gnt = mem_ce_i ? GNT_MEM : GNT_IF;
                end
            end
            ACCESS: begin
                if (wait_cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
                if ((grant == GNT_IF) ? mem_ce_i : if_ce_i) begin
                    start     = 1'b1;
                    start_gnt = ~grant;
                end
            end
            default: state_next = IDLE;
        endcase
        if (start) begin
            state_next = ACCESS;
        end
    end

    always_comb begin
        if_ready_o  = 1'b0;
        mem_ready_o = 1'b0;
        if (state == RESP) begin
            if_ready_o  = (grant == GNT_IF);
            mem_ready_o = (grant == GNT_MEM);
        end
    end

    assign stallreq_o = (if_ce_i & ~if_ready_o) | (mem_ce_i & ~mem_ready_o);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt   <= 4'd0;
            grant      <= GNT_IF;
            rr_last    <= GNT_IF;
            bus_ce_o   <= 1'b0;
            bus_we_o   <= 1'b0;
            bus_addr_o <= '0;
            bus_data_o <= '0;
            if_data_o  <= '0;
            mem_data_o <= '0;
        end else if (start) begin
            grant      <= start_gnt;
            wait_cnt   <= WAIT_INIT;
            bus_ce_o   <= 1'b1;
            bus_we_o   <= (start_gnt == GNT_MEM) ? mem_we_i : 1'b0;
            bus_addr_o <= (start_gnt == GNT_MEM) ? mem_addr_i : if_addr_i;
            bus_data_o <= (start_gnt == GNT_MEM) ? mem_data_i : '0;
        end else if (state == ACCESS) begin
            if (wait_cnt == 4'd0) begin
                // stores leave the read-data registers holding their last word
                if (!bus_we_o) begin
                    if (grant == GNT_MEM) begin
                        mem_data_o <= bus_data_i;
                    end else begin
                        if_data_o <= bus_data_i;
                    end
                end
                bus_ce_o <= 1'b0;
                bus_we_o <= 1'b0;
                rr_last  <= grant;
            end else begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter in three parameter configurations
module tb_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        if_ce;
    logic [31:0] if_addr;
    logic        mem_ce;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] bus_rd;

    logic [31:0] if_data_w   [3];
    logic        if_ready_w  [3];
    logic [31:0] mem_data_w  [3];
    logic        mem_ready_w [3];
    logic        bus_ce_w    [3];
    logic        bus_we_w    [3];
    logic [31:0] bus_addr_w  [3];
    logic [31:0] bus_wdata_w [3];
    logic        stall_w     [3];

    int sel;
    logic [31:0] o_if_data, o_mem_data, o_bus_addr, o_bus_wdata;
    logic        o_if_ready, o_mem_ready, o_bus_ce, o_bus_we, o_stall;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        is_mem;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic        rec_ce [0:31];
    logic        rec_we [0:31];
    logic        rec_ir [0:31];
    logic        rec_mr [0:31];
    logic        rec_st [0:31];
    logic [31:0] rec_addr [0:31];
    logic [31:0] rec_wd [0:31];

    // instance 0: WAIT=2 priority, 1: WAIT=2 round-robin, 2: WAIT=0 priority
    for (genvar g = 0; g < 3; g++) begin : g_dut
        bus_arbiter #(
            .DATA_W(32),
            .ADDR_W(32),
            .WAIT_CYCLES((g == 2) ? 0 : 2),
            .MEM_PRIORITY((g == 1) ? 0 : 1)
        ) dut (
            .clk(clk),
            .rst(rst),
            .if_ce_i(if_ce),
            .if_addr_i(if_addr),
            .if_data_o(if_data_w[g]),
            .if_ready_o(if_ready_w[g]),
            .mem_ce_i(mem_ce),
            .mem_we_i(mem_we),
            .mem_addr_i(mem_addr),
            .mem_data_i(mem_wdata),
            .mem_data_o(mem_data_w[g]),
            .mem_ready_o(mem_ready_w[g]),
            .bus_ce_o(bus_ce_w[g]),
            .bus_we_o(bus_we_w[g]),
            .bus_addr_o(bus_addr_w[g]),
            .bus_data_o(bus_wdata_w[g]),
            .bus_data_i(bus_rd),
            .stallreq_o(stall_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {~a[15:0], a[15:0]};
    endfunction

    always_comb begin
        o_if_data   = if_data_w[sel];
        o_if_ready  = if_ready_w[sel];
        o_mem_data  = mem_data_w[sel];
        o_mem_ready = mem_ready_w[sel];
        o_bus_ce    = bus_ce_w[sel];
        o_bus_we    = bus_we_w[sel];
        o_bus_addr  = bus_addr_w[sel];
        o_bus_wdata = bus_wdata_w[sel];
        o_stall     = stall_w[sel];
        bus_rd      = mem_f(o_bus_addr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (o_if_ready || o_mem_ready)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_ready", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_port", {63'd0, o_mem_ready}, {63'd0, e.is_mem});
                chk("sb_data", {32'd0, o_mem_ready ? o_mem_data : o_if_data}, {32'd0, e.data});
            end
        end
    end

    task automatic push(input logic is_mem, input logic [31:0] data);
        exp_t e;
        e.is_mem = is_mem;
        e.data   = data;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        if_ce  = 1'b0;
        mem_ce = 1'b0;
        mem_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // record n cycles after the sampling edge; requesters drop ce on their ready,
    // or, with hold set, both keep requesting until four responses have arrived
    task automatic run(input int n, input bit hold);
        int nrdy = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            rec_ce[k]   = o_bus_ce;
            rec_we[k]   = o_bus_we;
            rec_ir[k]   = o_if_ready;
            rec_mr[k]   = o_mem_ready;
            rec_st[k]   = o_stall;
            rec_addr[k] = o_bus_addr;
            rec_wd[k]   = o_bus_wdata;
            if (o_if_ready || o_mem_ready) nrdy++;
            if (!hold) begin
                if (o_if_ready) if_ce = 1'b0;
                if (o_mem_ready) mem_ce = 1'b0;
            end else if (nrdy == 4) begin
                if_ce  = 1'b0;
                mem_ce = 1'b0;
            end
        end
    endtask

    task automatic chk_mask(input string tag, input int n, input logic [31:0] ce_m,
                            input logic [31:0] we_m, input logic [31:0] ir_m,
                            input logic [31:0] mr_m, input logic [31:0] st_m);
        logic [31:0] c = '0, w = '0, i = '0, m = '0, s = '0;
        for (int k = 1; k <= n; k++) begin
            c[k-1] = rec_ce[k];
            w[k-1] = rec_we[k];
            i[k-1] = rec_ir[k];
            m[k-1] = rec_mr[k];
            s[k-1] = rec_st[k];
        end
        chk($sformatf("%s_bus_ce", tag), {32'd0, c}, {32'd0, ce_m});
        chk($sformatf("%s_bus_we", tag), {32'd0, w}, {32'd0, we_m});
        chk($sformatf("%s_if_ready", tag), {32'd0, i}, {32'd0, ir_m});
        chk($sformatf("%s_mem_ready", tag), {32'd0, m}, {32'd0, mr_m});
        chk($sformatf("%s_stall", tag), {32'd0, s}, {32'd0, st_m});
    endtask

    initial begin
        sel       = 0;
        rst       = 1'b1;
        if_ce     = 1'b0;
        if_addr   = '0;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk($sformatf("reset_bus_ce_%0d", s), {63'd0, o_bus_ce}, 64'd0);
            chk($sformatf("reset_ready_%0d", s), {62'd0, o_if_ready, o_mem_ready}, 64'd0);
            chk($sformatf("reset_data_%0d", s), {o_if_data, o_mem_data}, 64'd0);
            chk($sformatf("reset_bus_addr_%0d", s), {32'd0, o_bus_addr}, 64'd0);
        end
        sel = 0;
        rst = 1'b0;

        // fetch, WAIT=2
        do_reset();
        if_addr = 32'h100;
        if_ce   = 1'b1;
        push(1'b0, 32'hDEADBEEF);
        run(6, 1'b0);
        chk_mask("fetch", 6, 32'b000111, 32'b0, 32'b001000, 32'b0, 32'b000111);
        chk("fetch_addr", {32'd0, rec_addr[2]}, 64'h100);
        chk("fetch_data_hold", {32'd0, o_if_data}, 64'hDEADBEEF);
        chk("fetch_sb_empty", 64'(sb.size()), 64'd0);

        // store, WAIT=2
        do_reset();
        mem_we    = 1'b1;
        mem_addr  = 32'h20;
        mem_wdata = 32'h12345678;
        mem_ce    = 1'b1;
        push(1'b1, 32'h0);
        run(6, 1'b0);
        mem_we = 1'b0;
        chk_mask("store", 6, 32'b000111, 32'b000111, 32'b0, 32'b001000, 32'b000111);
        chk("store_wdata_first", {32'd0, rec_wd[1]}, 64'h12345678);
        chk("store_wdata_last", {32'd0, rec_wd[3]}, 64'h12345678);
        chk("store_addr", {32'd0, rec_addr[3]}, 64'h20);
        chk("store_data_unchanged", {32'd0, o_mem_data}, 64'd0);
        chk("store_sb_empty", 64'(sb.size()), 64'd0);

        // collision with MEM priority: MEM then IF back-to-back
        do_reset();
        if_addr  = 32'h200;
        mem_addr = 32'h300;
        if_ce    = 1'b1;
        mem_ce   = 1'b1;
        push(1'b1, mem_f(32'h300));
        push(1'b0, mem_f(32'h200));
        run(9, 1'b0);
        chk_mask("collide", 9, 32'b001110111, 32'b0, 32'b010000000, 32'b000001000, 32'b001111111);
        chk("collide_addr_mem", {32'd0, rec_addr[1]}, 64'h300);
        chk("collide_addr_if", {32'd0, rec_addr[5]}, 64'h200);
        chk("collide_sb_empty", 64'(sb.size()), 64'd0);

        // round robin: four continuous accesses, then a pointer-driven tie from IDLE
        sel = 1;
        do_reset();
        if_addr  = 32'h400;
        mem_addr = 32'h500;
        if_ce    = 1'b1;
        mem_ce   = 1'b1;
        push(1'b1, mem_f(32'h500));
        push(1'b0, mem_f(32'h400));
        push(1'b1, mem_f(32'h500));
        push(1'b0, mem_f(32'h400));
        run(18, 1'b1);
        chk_mask("rr", 18, 32'h07777, 32'b0, 32'h08080, 32'h00808, 32'h0FFFF);
        chk("rr_sb_empty", 64'(sb.size()), 64'd0);
        mem_ce = 1'b1;
        push(1'b1, mem_f(32'h500));
        run(6, 1'b0);
        if_ce  = 1'b1;
        mem_ce = 1'b1;
        push(1'b0, mem_f(32'h400));
        push(1'b1, mem_f(32'h500));
        run(9, 1'b0);
        chk("rr_tie_if_first", {32'd0, rec_addr[1]}, 64'h400);
        chk("rr_tie_sb_empty", 64'(sb.size()), 64'd0);

        // reset mid-access
        sel = 0;
        do_reset();
        mem_addr = 32'h600;
        mem_ce   = 1'b1;
        push(1'b1, mem_f(32'h600));
        run(6, 1'b0);
        chk("rst_pre_load", {32'd0, o_mem_data}, {32'd0, mem_f(32'h600)});
        mem_addr = 32'h680;
        mem_ce   = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_access_started", {63'd0, o_bus_ce}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_bus_ce", {63'd0, o_bus_ce}, 64'd0);
        chk("rst_ready", {62'd0, o_if_ready, o_mem_ready}, 64'd0);
        chk("rst_data", {o_if_data, o_mem_data}, 64'd0);
        chk("rst_stall_follows_inputs", {63'd0, o_stall}, 64'd1);
        rst    = 1'b0;
        mem_ce = 1'b0;
        run(5, 1'b0);
        chk_mask("rst_after", 5, 32'b0, 32'b0, 32'b0, 32'b0, 32'b0);
        chk("rst_sb_empty", 64'(sb.size()), 64'd0);

        // zero wait states
        sel = 2;
        do_reset();
        mem_addr = 32'h700;
        mem_ce   = 1'b1;
        push(1'b1, mem_f(32'h700));
        run(4, 1'b0);
        chk_mask("zero", 4, 32'b0001, 32'b0, 32'b0, 32'b0010, 32'b0001);
        chk("zero_data_hold", {32'd0, o_mem_data}, {32'd0, mem_f(32'h700)});
        chk("zero_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, address bus width in bits.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, legal range 0..15; extra bus cycles per access.
REQ-004 SHALL have parameter MEM_PRIORITY, default 1. 1 means the MEM port always wins. 0 means round-robin.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port if_ce_i, input, 1, fetch request; held until if_ready_o.
REQ-008 SHALL have port if_addr_i, input, ADDR_W, fetch address.
REQ-009 SHALL have port if_data_o, output, DATA_W, fetched word.
REQ-010 SHALL have port if_ready_o, output, 1, fetch complete, one-cycle pulse.
REQ-011 SHALL have port mem_ce_i, input, 1, load/store request; held until mem_ready_o.
REQ-012 SHALL have port mem_we_i, input, 1, 1 means store.
REQ-013 SHALL have port mem_addr_i, input, ADDR_W, load/store address.
REQ-014 SHALL have port mem_data_i, input, DATA_W, store data.
REQ-015 SHALL have port mem_data_o, output, DATA_W, load data.
REQ-016 SHALL have port mem_ready_o, output, 1, load/store complete, one-cycle pulse.
REQ-017 SHALL have port bus_ce_o, output, 1, shared memory chip enable.
REQ-018 SHALL have port bus_we_o, output, 1, shared memory write enable.
REQ-019 SHALL have port bus_addr_o, output, ADDR_W, shared memory address.
REQ-020 SHALL have port bus_data_o, output, DATA_W, shared memory write data.
REQ-021 SHALL have port bus_data_i, input, DATA_W, shared memory read data.
REQ-022 SHALL have port stallreq_o, output, 1, pipeline stall request to ctrl.

Function
REQ-023 SHALL implement states IDLE, ACCESS and RESP, plus a 4-bit wait counter and a registered grant (IF or MEM).
REQ-024 SHALL, in IDLE, on an edge where any ce_i is high: grant a port, latch its address, we and write data onto the bus_* registers, load counter with WAIT_CYCLES, and enter ACCESS.
REQ-025 SHALL resolve a simultaneous request as follows: with MEM_PRIORITY=1, grant MEM. With MEM_PRIORITY=0, grant the port not served last; the pointer starts at IF after reset, so MEM wins the first tie.
REQ-026 SHALL hold bus_ce_o=1 and bus_addr_o/bus_we_o/bus_data_o stable for exactly WAIT_CYCLES+1 cycles in ACCESS; the counter decrements each edge.
REQ-027 SHALL, on the edge where counter==0 in ACCESS, capture bus_data_i into the granted port's data_o register (loads/fetches only), drop bus_ce_o and bus_we_o, and enter RESP.
REQ-028 SHALL assert the granted port's ready_o for exactly the one cycle spent in RESP.
REQ-029 SHALL make end-to-end latency fixed: ready_o rises WAIT_CYCLES+2 edges after the edge that first sampled ce_i, when no other access is in flight.
REQ-030 SHALL, in RESP, ignore the just-served port's ce_i. If the other port's ce_i is high, go directly to ACCESS for it (back-to-back, no IDLE bubble); otherwise go to IDLE.
REQ-031 SHALL leave if_data_o/mem_data_o unchanged on a store and between accesses; they hold the last captured word.
REQ-032 SHALL update the round-robin pointer to the served port on each ACCESS-to-RESP transition.
REQ-033 SHALL complete an access even if its ce_i drops mid-ACCESS; ready still pulses, and the requester is responsible for ignoring it.
REQ-034 SHALL drive stallreq_o combinationally as (if_ce_i & ~if_ready_o) | (mem_ce_i & ~mem_ready_o).
REQ-035 SHALL, with WAIT_CYCLES=0, keep ACCESS for exactly one cycle (capture at the first ACCESS edge).

Reset
REQ-036 SHALL, on rst=1 at an edge, force state IDLE, counter 0, pointer IF, and all bus_* outputs, data_o and ready_o to 0; this takes effect the following cycle.
REQ-037 SHALL abort an access in progress at reset with no ready pulse and no data capture; stallreq_o still follows REQ-034 from the inputs.

Verification
REQ-038 SHALL cover fetch latency: WAIT_CYCLES=2, if_ce_i=1 at if_addr_i=0x100, bus_data_i=0xDEADBEEF -> bus_ce_o high 3 cycles with bus_addr_o=0x100, if_ready_o 1-cycle pulse 4 edges after sampling, if_data_o=0xDEADBEEF.
REQ-039 SHALL cover store: mem_ce_i=1, mem_we_i=1, mem_addr_i=0x20, mem_data_i=0x12345678 -> bus_we_o=1 for WAIT_CYCLES+1 cycles with bus_data_o=0x12345678, mem_ready_o pulses, mem_data_o unchanged.
REQ-040 SHALL cover collision with MEM_PRIORITY=1: both ce_i rise together -> MEM served first, then IF back-to-back from RESP (no IDLE cycle); stallreq_o stays 1 until if_ready_o.
REQ-041 SHALL cover round robin with MEM_PRIORITY=0: both ports request continuously for four accesses -> grant order MEM, IF, MEM, IF.
REQ-042 SHALL cover reset mid-access: rst=1 on the second ACCESS edge -> next cycle bus_ce_o=0, no ready pulse, data_o=0, state IDLE.
REQ-043 SHALL cover zero wait: WAIT_CYCLES=0, a single load -> bus_ce_o high 1 cycle, mem_ready_o 2 edges after sampling.
